// File: rtl/cpr_pacer.sv
// CPR pacing sequencer: lamp test, then repeated compress/breathe sets with a
// pulse check every ROUNDS_PER_CHECK rounds; a debounced start press toggles sessions.
module cpr_pacer #(
    parameter int unsigned DEBOUNCE_LEN     = 3,
    parameter int unsigned LAMP_CYCLES      = 1000,
    parameter int unsigned BEAT_PERIOD      = 25_000_000,
    parameter int unsigned BEAT_ON          = 11_500_000,
    parameter int unsigned COMP_ADULT       = 30,
    parameter int unsigned COMP_CHILD       = 15,
    parameter int unsigned BREATHS          = 2,
    parameter int unsigned BREATH_PERIOD    = 50_000_000,
    parameter int unsigned BREATH_ON        = 25_000_000,
    parameter int unsigned ROUNDS_PER_CHECK = 5,
    parameter int unsigned CHECK_CYCLES     = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic       compress_out,
    output logic       breath_out,
    output logic       pulse_out,
    output logic [2:0] state_out,
    output logic [7:0] comp_count,
    output logic [3:0] round_count,
    output logic [3:0] io_oeb,
    output logic       sync
);

    localparam logic [31:0] LAMP_LAST   = 32'(LAMP_CYCLES - 1);
    localparam logic [31:0] BEAT_LAST   = 32'(BEAT_PERIOD - 1);
    localparam logic [31:0] BREATH_LAST = 32'(BREATH_PERIOD - 1);
    localparam logic [31:0] CHECK_LAST  = 32'(CHECK_CYCLES - 1);
    localparam logic [31:0] BEAT_ON_T   = 32'(BEAT_ON);
    localparam logic [31:0] BREATH_ON_T = 32'(BREATH_ON);
    localparam logic [7:0]  COMP_A_N    = 8'(COMP_ADULT);
    localparam logic [7:0]  COMP_C_N    = 8'(COMP_CHILD);
    localparam logic [7:0]  BREATHS_N   = 8'(BREATHS);
    localparam logic [3:0]  ROUNDS_N    = 4'(ROUNDS_PER_CHECK);

    typedef enum logic [2:0] {
        ST_LAMP     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_COMPRESS = 3'd2,
        ST_BREATHE  = 3'd3,
        ST_CHECK    = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             t_q, t_d;
    logic [7:0]              comp_q, comp_d;
    logic [7:0]              brth_q, brth_d;
    logic [3:0]              round_q, round_d;
    logic                    mode_q, mode_d;
    logic [DEBOUNCE_LEN-1:0] sh_q, sh_d;
    logic                    deb_q, deb_d;
    logic                    press;
    logic [7:0]              comp_lim;

    // Debounce shift register; a press is the rising edge of "all samples high".
    generate
        if (DEBOUNCE_LEN == 1) begin : g_sh1
            assign sh_d = start;
        end else begin : g_shn
            assign sh_d = {sh_q[DEBOUNCE_LEN-2:0], start};
        end
    endgenerate

    assign deb_d    = &sh_q;
    assign press    = deb_d & ~deb_q;
    assign comp_lim = mode_q ? COMP_C_N : COMP_A_N;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LAMP;
            t_q     <= '0;
            comp_q  <= '0;
            brth_q  <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            sh_q    <= '0;
            deb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            comp_q  <= comp_d;
            brth_q  <= brth_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            sh_q    <= sh_d;
            deb_q   <= deb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        comp_d  = comp_q;
        brth_d  = brth_q;
        round_d = round_q;
        mode_d  = mode_q;
        case (state_q)
            ST_LAMP: begin
                if (t_q == LAMP_LAST) begin
                    state_d = ST_IDLE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 32'd1;
                end
            end
            ST_IDLE: begin
                t_d     = '0;
                comp_d  = '0;
                brth_d  = '0;
                round_d = '0;
                if (press) begin
                    mode_d  = mode;
                    state_d = ST_COMPRESS;
                end
            end
            ST_COMPRESS: begin
                if (t_q == BEAT_LAST) begin
                    t_d    = '0;
                    comp_d = comp_q + 8'd1;
                    if (comp_d == comp_lim) begin
                        state_d = ST_BREATHE;
                        brth_d  = '0;
                    end
                end else begin
                    t_d = t_q + 32'd1;
                end
            end
            ST_BREATHE: begin
                if (t_q == BREATH_LAST) begin
                    t_d    = '0;
                    brth_d = brth_q + 8'd1;
                    if (brth_d == BREATHS_N) begin
                        brth_d  = '0;
                        comp_d  = '0;
                        round_d = round_q + 4'd1;
                        state_d = (round_d == ROUNDS_N) ? ST_CHECK : ST_COMPRESS;
                    end
                end else begin
                    t_d = t_q + 32'd1;
                end
            end
            ST_CHECK: begin
                if (t_q == CHECK_LAST) begin
                    t_d     = '0;
                    round_d = '0;
                    state_d = ST_COMPRESS;
                end else begin
                    t_d = t_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
                comp_d  = '0;
                brth_d  = '0;
                round_d = '0;
            end
        endcase
        // A press during a session aborts it, overriding any phase-end move.
        if (press && (state_q == ST_COMPRESS || state_q == ST_BREATHE || state_q == ST_CHECK)) begin
            state_d = ST_IDLE;
            t_d     = '0;
            comp_d  = '0;
            brth_d  = '0;
            round_d = '0;
        end
    end

    always_comb begin
        compress_out = 1'b0;
        breath_out   = 1'b0;
        pulse_out    = 1'b0;
        case (state_q)
            ST_LAMP: begin
                compress_out = 1'b1;
                breath_out   = 1'b1;
                pulse_out    = 1'b1;
            end
            ST_COMPRESS: compress_out = (t_q < BEAT_ON_T);
            ST_BREATHE:  breath_out   = (t_q < BREATH_ON_T);
            ST_CHECK:    pulse_out    = 1'b1;
            default: ;
        endcase
    end

    assign state_out   = state_q;
    assign comp_count  = comp_q;
    assign round_count = round_q;
    assign io_oeb      = 4'b0000;
    assign sync        = rst;

endmodule
